// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-ported
// memory, one transaction in flight, with anti-starvation for fetches.
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    input  logic             if_flush,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_valid,
    output logic             if_stall,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    input  logic [3:0]       dm_be,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             dm_valid,
    output logic             dm_stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             proto_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;   // 1 = data port owns the transaction
    logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d, starve_q, starve_d;
    logic             discard_q, discard_d, perr_q, perr_d;
    logic             pick_data;

    // Data normally wins; a fetch that has waited STARVE_MAX data grants goes first.
    assign pick_data = dm_req && !(if_req && starve_q == SMAX);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        be_d      = be_q;
        starve_d  = starve_q;
        discard_d = discard_q;
        perr_d    = perr_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if_valid  = 1'b0;
        if_rdata  = '0;
        dm_valid  = 1'b0;
        dm_rdata  = '0;
        case (state_q)
            IDLE: begin
                if (mem_rvalid) perr_d = 1'b1;
                if (if_req || dm_req) begin
                    state_d   = REQ;
                    owner_d   = pick_data;
                    discard_d = 1'b0;
                    if (pick_data) begin
                        addr_d  = dm_addr;
                        we_d    = dm_we;
                        wdata_d = dm_wdata;
                        be_d    = dm_be;
                        if (if_req && starve_q != SMAX) starve_d = starve_q + 4'd1;
                    end else begin
                        addr_d   = if_addr;
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        be_d     = 4'hF;
                        starve_d = '0;
                    end
                end
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_be    = be_q;
                // A response before the grant is a memory-side violation, never a completion.
                if (mem_rvalid) perr_d = 1'b1;
                if (if_flush && !owner_q) discard_d = 1'b1;
                if (mem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    if (owner_q) begin
                        dm_valid = 1'b1;
                        dm_rdata = mem_rdata;
                    end else if (!discard_q && !if_flush) begin
                        if_valid = 1'b1;
                        if_rdata = mem_rdata;
                    end
                end else if (if_flush && !owner_q) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            mem_be    = '0;
            if_valid  = 1'b0;
            if_rdata  = '0;
            dm_valid  = 1'b0;
            dm_rdata  = '0;
        end
    end

    assign if_stall  = if_req & ~if_valid;
    assign dm_stall  = dm_req & ~dm_valid;
    assign proto_err = perr_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            starve_q  <= '0;
            discard_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            be_q      <= be_d;
            starve_q  <= starve_d;
            discard_q <= discard_d;
            perr_q    <= perr_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;
    localparam int W  = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, dm_req, dm_we, mem_gnt, mem_rvalid;
    logic [W-1:0]  if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]    dm_be;
    logic [W-1:0]  if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic          if_valid, if_stall, dm_valid, dm_stall, mem_req, mem_we, proto_err;
    logic [3:0]    mem_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(W), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .proto_err(proto_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level model: an optional in-flight transaction record.
    bit          t_live, t_granted, t_data, t_drop, t_perr;
    bit          t_we;
    logic [W-1:0] t_addr, t_wdata;
    logic [3:0]  t_be;
    int          waited;            // data grants handed out while a fetch was waiting
    bit          e_req, e_done, e_ifv, e_dmv;
    bit          if_done, dm_done;

    // Memory responder state (stimulus side).
    bit auto_mem;
    int gnt_pct, max_dly, dly;
    bit pend;

    task automatic settle();
        #1;
        e_req  = !rst && t_live && !t_granted;
        e_done = !rst && t_live && t_granted && mem_rvalid;
        e_ifv  = e_done && !t_data && !t_drop && !if_flush;
        e_dmv  = e_done && t_data;
        chk("mem_req", mem_req, e_req);
        chk("mem_we", mem_we, e_req ? t_we : 1'b0);
        if (e_req) begin
            chk("mem_addr", mem_addr, t_addr);
            chk("mem_be", mem_be, t_be);
            if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
        end
        chk("if_valid", if_valid, e_ifv);
        chk("dm_valid", dm_valid, e_dmv);
        if (e_ifv) chk("if_rdata", if_rdata, mem_rdata);
        if (e_dmv && !t_we) chk("dm_rdata", dm_rdata, mem_rdata);
        chk("if_stall", if_stall, if_req && !e_ifv);
        chk("dm_stall", dm_stall, dm_req && !e_dmv);
        chk("proto_err", proto_err, t_perr && !rst);
    endtask

    task automatic model_update();
        if_done = e_ifv;
        dm_done = e_dmv;
        if (rst) begin
            t_live = 0; t_granted = 0; t_drop = 0; t_perr = 0; waited = 0;
        end else if (!t_live) begin
            if (mem_rvalid) t_perr = 1;
            if (if_req || dm_req) begin
                t_live = 1; t_granted = 0; t_drop = 0;
                t_data = dm_req && !(if_req && waited == SM);
                if (t_data) begin
                    t_addr = dm_addr; t_we = dm_we; t_wdata = dm_wdata; t_be = dm_be;
                    if (if_req) waited = (waited + 1 > SM) ? SM : waited + 1;
                end else begin
                    t_addr = if_addr; t_we = 0; t_wdata = '0; t_be = 4'hF;
                    waited = 0;
                end
            end
        end else if (!t_granted) begin
            if (mem_rvalid) t_perr = 1;
            if (if_flush && !t_data) t_drop = 1;
            if (mem_gnt) t_granted = 1;
        end else if (mem_rvalid) begin
            t_live = 0; t_drop = 0;
        end else if (if_flush && !t_data) begin
            t_drop = 1;
        end
    endtask

    task automatic drive_mem();
        mem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        mem_rvalid = pend && (dly == 0);
        mem_rdata  = $urandom;
    endtask

    task automatic responder_update();
        if (rst) pend = 0;
        else if (pend) begin
            if (mem_rvalid) pend = 0;
            else if (dly > 0) dly--;
        end else if (e_req && mem_gnt) begin
            pend = 1;
            dly  = $urandom_range(0, max_dly);
        end
    endtask

    task automatic tick();
        model_update();
        responder_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 0; if_flush = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        settle();
        tick();
        rst = 0;
        settle();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_proto_err", proto_err, 1'b0);
    endtask

    task automatic gen_stim();
        if (!if_req) begin
            if ($urandom_range(0, 3) == 0) begin if_req = 1; if_addr = $urandom; end
        end else if (if_done || $urandom_range(0, 40) == 0) begin
            if_req = $urandom_range(0, 1); if_addr = $urandom;
        end
        if_flush = ($urandom_range(0, 9) == 0);
        if (!dm_req || dm_done || $urandom_range(0, 40) == 0) begin
            dm_req   = (!dm_req) ? ($urandom_range(0, 2) == 0) : $urandom_range(0, 1);
            dm_we    = $urandom_range(0, 1);
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            dm_be    = 4'($urandom_range(0, 15));
        end
        drive_mem();
        rst = ($urandom_range(0, 399) == 0);
    endtask

    initial begin
        string seq, want;
        int    nv;
        auto_mem = 0; gnt_pct = 100; max_dly = 0; pend = 0; dly = 0;
        t_live = 0; t_granted = 0; t_data = 0; t_drop = 0; t_perr = 0; waited = 0;
        t_we = 0; t_addr = '0; t_wdata = '0; t_be = '0;
        if_done = 0; dm_done = 0;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        do_reset();
        tick();

        // Minimum-latency fetch.
        if_req = 1; if_addr = 32'h100;
        settle(); chk("f_c0_mem_req", mem_req, 1'b0); tick();
        mem_gnt = 1;
        settle(); chk("f_c1_mem_req", mem_req, 1'b1); chk("f_c1_addr", mem_addr, 32'h100); tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        settle(); chk("f_c2_valid", if_valid, 1'b1); chk("f_c2_rdata", if_rdata, 32'hDEADBEEF);
        tick();

        // Store with the grant held off for three cycles.
        do_reset();
        dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h12345678; dm_be = 4'b0011;
        settle(); tick();
        for (int k = 0; k < 4; k++) begin
            mem_gnt = (k == 3);
            settle();
            chk("st_mem_req", mem_req, 1'b1);
            chk("st_addr", mem_addr, 32'h40);
            chk("st_wdata", mem_wdata, 32'h12345678);
            chk("st_be", mem_be, 4'b0011);
            chk("st_we", mem_we, 1'b1);
            tick();
        end
        mem_gnt = 0; mem_rvalid = 1;
        settle(); chk("st_valid", dm_valid, 1'b1); tick();
        dm_req = 0; mem_rvalid = 0;
        settle(); chk("st_valid_once", dm_valid, 1'b0); tick();

        // Flushed fetch is discarded; the following fetch completes.
        do_reset();
        if_req = 1; if_addr = 32'h200;
        settle(); tick();
        mem_gnt = 1; settle(); tick();
        mem_gnt = 0; if_flush = 1; settle(); tick();
        if_flush = 0; mem_rvalid = 1; mem_rdata = 32'h11111111;
        settle(); chk("fl_suppressed", if_valid, 1'b0); chk("fl_stall", if_stall, 1'b1); tick();
        mem_rvalid = 0; settle(); chk("fl_reselect", mem_req, 1'b0); tick();
        mem_gnt = 1; settle(); chk("fl_req2", mem_req, 1'b1); tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        settle(); chk("fl_valid2", if_valid, 1'b1); chk("fl_rdata2", if_rdata, 32'hCAFEF00D); tick();

        // Reset while waiting: response during reset is dropped, one after it is an error.
        do_reset();
        if_req = 1; if_addr = 32'h300;
        settle(); tick();
        mem_gnt = 1; settle(); tick();
        mem_gnt = 0; if_req = 0; rst = 1; mem_rvalid = 1;
        settle(); chk("rw_valid", if_valid, 1'b0); chk("rw_mem_req", mem_req, 1'b0); tick();
        rst = 0; mem_rvalid = 0;
        settle(); chk("rw_perr0", proto_err, 1'b0); tick();
        mem_rvalid = 1;
        settle(); chk("rw_late_valid", if_valid, 1'b0); tick();
        mem_rvalid = 0;
        settle(); chk("rw_perr1", proto_err, 1'b1); tick();

        // Stray response in IDLE is sticky until reset.
        do_reset();
        mem_rvalid = 1; settle(); tick();
        mem_rvalid = 0;
        for (int k = 0; k < 3; k++) begin settle(); tick(); end
        settle(); chk("idle_perr_sticky", proto_err, 1'b1);
        do_reset();

        // Grant and response together in REQ: grant honoured, response flagged.
        dm_req = 1; dm_we = 0; dm_addr = 32'h80;
        settle(); tick();
        mem_gnt = 1; mem_rvalid = 1;
        settle(); chk("gr_valid", dm_valid, 1'b0); tick();
        mem_gnt = 0; mem_rvalid = 0;
        settle(); chk("gr_perr", proto_err, 1'b1); chk("gr_wait", mem_req, 1'b0); tick();
        mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
        settle(); chk("gr_valid2", dm_valid, 1'b1); chk("gr_rdata", dm_rdata, 32'h0BADF00D); tick();

        // Both ports held with a one-cycle memory: starvation order.
        do_reset();
        auto_mem = 1; gnt_pct = 100; max_dly = 0; pend = 0;
        seq = ""; nv = 0;
        for (int c = 0; c < 60 && nv < 10; c++) begin
            if_req = 1; if_addr = 32'h1000; dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
            drive_mem();
            settle();
            if (dm_valid) begin seq = {seq, "D"}; nv++; end
            if (if_valid) begin seq = {seq, "F"}; nv++; end
            tick();
        end
        want = "DDDDFDDDDF";
        n_chk++;
        if (seq == want) n_pass++;
        else $display("FAIL starve_order: got %s, expected %s", seq, want);

        // Randomized traffic.
        do_reset();
        gnt_pct = 60; max_dly = 2; pend = 0;
        for (int c = 0; c < 3000; c++) begin
            gen_stim();
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, data/address width; STARVE_MAX, 4, consecutive data grants tolerated while a fetch waits (range 1-15).
REQ-002 Clock and reset SHALL be: one clock `clk`; reset `rst`, synchronous, active-high.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  WIDTH  fetch address
- if_flush  in  1  discard current or pending fetch response
- if_rdata  out  WIDTH  fetch data; valid only with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  fetch stage must hold PC
- dm_req  in  1  data request; held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  WIDTH  data address
- dm_wdata  in  WIDTH  store data
- dm_be  in  4  store byte enables
- dm_rdata  out  WIDTH  load data; valid only with dm_valid
- dm_valid  out  1  one-cycle data completion pulse
- dm_stall  out  1  MEM stage must hold
- mem_req  out  1  request to single-ported memory
- mem_we  out  1  write strobe
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_be  out  4  memory byte enables
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  memory response; reads and writes
- mem_rdata  in  WIDTH  memory read data
- proto_err  out  1  sticky protocol-violation flag

Function
REQ-004 FSM SHALL have states IDLE, REQ, WAIT; one transaction outstanding at most.
REQ-005 In IDLE with any request: select owner, latch owner, addr, we, wdata, be (fetch: we=0, be=4'hF); next state REQ.
REQ-006 Arbitration SHALL be: data wins when both request, unless starve_cnt==STARVE_MAX, then fetch wins.
REQ-007 starve_cnt SHALL increment, saturating at STARVE_MAX, on each data selection made while if_req=1; it clears on any fetch selection.
REQ-008 In REQ, mem_req=1 and mem_* SHALL be driven from the latched registers only; mem_gnt=1 moves to WAIT, otherwise stay in REQ.
REQ-009 In IDLE and WAIT, mem_req=0 and mem_we=0.
REQ-010 In WAIT, mem_rvalid=1 SHALL complete the transaction: next state IDLE; in the same cycle, pulse the owner's valid with rdata=mem_rdata, combinationally.
REQ-011 dm_valid SHALL pulse for stores as well as loads; dm_rdata is don't-care for stores.
REQ-012 Minimum latency: request seen in cycle 0, mem_req in cycle 1, gnt in cycle 1, rvalid in cycle 2 gives valid in cycle 2.
REQ-013 A new selection SHALL occur no earlier than the cycle after completion (IDLE re-entry); no back-to-back issue in the completion cycle.
REQ-014 if_stall SHALL be if_req & ~if_valid; dm_stall SHALL be dm_req & ~dm_valid; both combinational.
REQ-015 if_flush in any cycle while fetch-owned (REQ or WAIT), or in the completion cycle, SHALL set a discard flag; the memory transaction still completes, but if_valid is suppressed; the flag clears at completion.
REQ-016 If the requester drops its req mid-transaction, the transaction SHALL still complete and the valid pulse is still issued.
REQ-017 mem_rvalid while in IDLE or REQ SHALL be ignored and SHALL set proto_err; proto_err clears only on rst.
REQ-018 Simultaneous mem_gnt and mem_rvalid in REQ: gnt SHALL be honoured and rvalid treated per REQ-017.

Reset
REQ-019 rst SHALL force IDLE, clear starve_cnt, the discard flag, proto_err and all latched registers, and drive all outputs to 0 (stalls follow REQ-014), including mid-transaction; any in-flight response is dropped.

Verification
REQ-020 Fetch only, addr 0x100, gnt in cycle 1, rvalid with 0xDEADBEEF in cycle 2 -> mem_addr=0x100 in cycle 1; if_valid=1 and if_rdata=0xDEADBEEF in cycle 2.
REQ-021 if_req and dm_req held continuously (STARVE_MAX=4), 1-cycle memory -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-022 Store dm_addr=0x40, wdata=0x12345678, be=4'b0011, gnt stalled 3 cycles -> mem_req held 3+1 cycles with stable 0x40/0x12345678/0011; dm_valid pulses once on rvalid.
REQ-023 Fetch in WAIT with if_flush pulsed -> no if_valid; FSM returns to IDLE on rvalid; next fetch completes normally.
REQ-024 rst asserted in WAIT, then rvalid arrives -> no valid pulse, proto_err=1 only if rvalid comes after rst deasserts, FSM in IDLE.
REQ-025 mem_rvalid injected in IDLE -> proto_err=1 and stays 1 until rst.
